// File: rtl/demux8_deser.sv
// demux8_deser: serial-to-parallel demux assembling WIDTH-bit words behind a valid/ready port
module demux8_deser #(
  parameter int WIDTH = 8,
  parameter bit MSB_FIRST = 1'b0,
  parameter int SEL_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic             in_sof,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SEL_W-1:0] sel,
  output logic             locked,
  output logic             sync_err,
  output logic             overflow,
  input  logic             clr_ovf
);
  typedef enum logic {IDLE, FILL} state_t;
  state_t state;
  logic [WIDTH-1:0] assembly, merged;
  logic [SEL_W-1:0] pos, lane;
  logic take, done, free;
  // a sof always restarts the word at position 0, discarding any partial word
  always_comb begin
    take = in_valid & (state == FILL | in_sof);
    pos = in_sof ? '0 : sel;
    lane = MSB_FIRST ? SEL_W'(WIDTH - 1) - pos : pos;
    merged = assembly;
    merged[lane] = in_bit;
    done = take & (pos == SEL_W'(WIDTH - 1));
    free = ~out_valid | out_ready;
  end
  assign locked = state == FILL;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel <= '0;
      assembly <= '0;
      out_data <= '0;
      out_valid <= 1'b0;
      sync_err <= 1'b0;
      overflow <= 1'b0;
    end else begin
      sync_err <= take & in_sof & (sel != '0);
      if (take) begin
        state <= FILL;
        assembly <= merged;
        sel <= done ? '0 : pos + SEL_W'(1);
      end
      if (done & free) begin
        out_data <= merged;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      overflow <= (done & ~free) | (overflow & ~clr_ovf);
    end
  end
endmodule

// File: tb/tb_demux8_deser.sv
// tb_demux8_deser: directed and random checks of LSB-first and MSB-first demux instances
module tb_demux8_deser;
  logic clk = 0, rst = 0, in_bit = 0, in_valid = 0, in_sof = 0, out_ready = 0, clr_ovf = 0;
  logic [7:0] d0, d1;
  logic [2:0] s0, s1;
  logic v0, v1, l0, l1, e0, e1, o0, o1;
  int vectors = 0, miscompares = 0;
  bit q[$];
  bit m_locked, m_valid, m_err, m_ovf;
  logic [7:0] m_d0, m_d1;

  demux8_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .in_sof(in_sof),
    .out_data(d0), .out_valid(v0), .out_ready(out_ready), .sel(s0), .locked(l0),
    .sync_err(e0), .overflow(o0), .clr_ovf(clr_ovf));
  demux8_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .in_sof(in_sof),
    .out_data(d1), .out_valid(v1), .out_ready(out_ready), .sel(s1), .locked(l1),
    .sync_err(e1), .overflow(o1), .clr_ovf(clr_ovf));

  always #5 clk = ~clk;

  function automatic logic [7:0] pack(input bit msb);
    logic [7:0] w;
    w = '0;
    foreach (q[i]) w[msb ? 7 - i : i] = q[i];
    return w;
  endfunction

  // one clock: drive at negedge, advance the word-level model at the edge, settle #1 after
  task automatic cyc(input bit b, v, s, r, c, rs);
    bit set, load;
    @(negedge clk);
    in_bit = b; in_valid = v; in_sof = s; out_ready = r; clr_ovf = c; rst = rs;
    @(posedge clk);
    set = 0; load = 0;
    if (rs) begin
      q.delete();
      m_locked = 0; m_valid = 0; m_err = 0; m_ovf = 0; m_d0 = 0; m_d1 = 0;
    end else begin
      m_err = 0;
      if (v && (m_locked || s)) begin
        if (s) begin
          m_err = q.size() != 0;
          q.delete();
        end
        q.push_back(b);
        m_locked = 1;
        if (q.size() == 8) begin
          if (!m_valid || r) begin
            m_d0 = pack(0); m_d1 = pack(1); load = 1;
          end else set = 1;
          q.delete();
        end
      end
      m_valid = load || (m_valid && !r);
      m_ovf = set || (m_ovf && !c);
    end
    #1;
  endtask

  task automatic send(input logic [7:0] w, input bit sof_first, input bit r);
    for (int i = 0; i < 8; i++) cyc(w[i], 1, sof_first && i == 0, r, 0, 0);
  endtask

  task automatic test_reset;
    cyc(0, 0, 0, 0, 0, 1);
    vectors++;
    if ({d0, d1, v0, v1, s0, s1, l0, l1, e0, e1, o0, o1} !== 30'd0) begin
      miscompares++;
      $display("FAIL reset_state got %h expected 0", {d0, d1, v0, v1, s0, s1, l0, l1, e0, e1, o0, o1});
    end
  endtask

  task automatic test_basic;
    cyc(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 7; i++) cyc(8'hAD >> i, 1, i == 0, 1, 0, 0);
    vectors++;
    if (v0 !== 1'b0 || s0 !== 3'd7) begin
      miscompares++;
      $display("FAIL basic_pre got v=%b sel=%0d expected v=0 sel=7", v0, s0);
    end
    cyc(1, 1, 0, 1, 0, 0);
    vectors++;
    if (d0 !== 8'hAD || v0 !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_lsb got %h/%b expected ad/1", d0, v0);
    end
    vectors++;
    if (d1 !== 8'hB5 || v1 !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_msb got %h/%b expected b5/1", d1, v1);
    end
  endtask

  task automatic test_back_to_back;
    cyc(0, 0, 0, 0, 0, 1);
    send(8'h3C, 1, 1);
    vectors++;
    if (d0 !== 8'h3C || s0 !== 3'd0 || l0 !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_first got %h sel=%0d lock=%b expected 3c 0 1", d0, s0, l0);
    end
    send(8'hC3, 0, 1);
    vectors++;
    if (d0 !== 8'hC3 || d1 !== m_d1 || v0 !== 1'b1 || l0 !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_second got %h/%h v=%b expected c3/%h v=1", d0, d1, v0, m_d1);
    end
  endtask

  task automatic test_overflow;
    cyc(0, 0, 0, 0, 0, 1);
    send(8'h11, 1, 0);
    send(8'h22, 0, 0);
    vectors++;
    if (d0 !== 8'h11 || v0 !== 1'b1 || o0 !== 1'b1 || o1 !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_hold got %h v=%b ovf=%b%b expected 11 1 11", d0, v0, o0, o1);
    end
    cyc(0, 0, 0, 1, 0, 0);
    vectors++;
    if (v0 !== 1'b0 || o0 !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_drain got v=%b ovf=%b expected 0 1", v0, o0);
    end
    cyc(0, 0, 0, 0, 1, 0);
    vectors++;
    if (o0 !== 1'b0 || o1 !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_clear got %b%b expected 00", o0, o1);
    end
  endtask

  task automatic test_resync;
    int errs = 0, words = 0;
    logic [7:0] got = 0;
    cyc(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(i[0], 1, i == 0, 1, 0, 0);
    vectors++;
    if (s0 !== 3'd5) begin
      miscompares++;
      $display("FAIL resync_sel got %0d expected 5", s0);
    end
    for (int i = 0; i < 10; i++) begin
      if (i < 8) cyc(8'h5A >> i, 1, i == 0, 1, 0, 0);
      else cyc(0, 0, 0, 1, 0, 0);
      errs += e0;
      if (v0) begin
        words++;
        got = d0;
      end
    end
    vectors++;
    if (errs != 1 || words != 1 || got !== 8'h5A) begin
      miscompares++;
      $display("FAIL resync got errs=%0d words=%0d data=%h expected 1 1 5a", errs, words, got);
    end
  endtask

  task automatic test_reset_mid;
    cyc(0, 0, 0, 0, 0, 1);
    send(8'h77, 1, 0);
    for (int i = 0; i < 4; i++) cyc(1, 1, i == 0, 0, 0, 0);
    vectors++;
    if (s0 !== 3'd4 || v0 !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_pre got sel=%0d v=%b expected 4 1", s0, v0);
    end
    cyc(1, 1, 0, 0, 0, 1);
    vectors++;
    if ({d0, d1, v0, v1, s0, s1, l0, l1, e0, e1, o0, o1} !== 30'd0) begin
      miscompares++;
      $display("FAIL rstmid_zero got %h expected 0", {d0, d1, v0, v1, s0, s1, l0, l1, e0, e1, o0, o1});
    end
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0, 0);
    vectors++;
    if (s0 !== 3'd0 || l0 !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_idle got sel=%0d lock=%b expected 0 0", s0, l0);
    end
    cyc(1, 1, 1, 0, 0, 0);
    vectors++;
    if (s0 !== 3'd1 || l0 !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_sof got sel=%0d lock=%b expected 1 1", s0, l0);
    end
  endtask

  task automatic test_random;
    cyc(0, 0, 0, 0, 0, 1);
    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(1, 0), $urandom_range(3, 0) != 0, $urandom_range(11, 0) == 0,
          $urandom_range(1, 0), $urandom_range(15, 0) == 0, $urandom_range(199, 0) == 0);
      vectors++;
      if ({d0, d1, v0, v1, s0, s1, l0, l1, e0, e1, o0, o1} !==
          {m_d0, m_d1, m_valid, m_valid, 3'(q.size()), 3'(q.size()), m_locked, m_locked,
           m_err, m_err, m_ovf, m_ovf}) begin
        miscompares++;
        $display("FAIL random[%0d] got d=%h/%h v=%b sel=%0d lk=%b err=%b ovf=%b expected d=%h/%h v=%b sel=%0d lk=%b err=%b ovf=%b",
                 n, d0, d1, v0, s0, l0, e0, o0, m_d0, m_d1, m_valid, q.size(), m_locked, m_err, m_ovf);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_overflow;
    test_resync;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
